pll_rst_seq: RTL and testbench
==============================

# pll_rst_seq

Reset and lock sequencer for the video-clock PLL (50 MHz reference in, 40.317 MHz core clock out). It runs on the reference clock and generates the PLL reset pulse. It waits for a filtered, stable `locked` before releasing the core reset. It re-initialises the PLL on lock timeout, on loss of lock, or on request. It sits between the top-level reset/OSD logic and the PLL wrapper, and it is the single source of `core_rst` for the game core.

## Interface

Parameters:

- `RST_CYCLES`, 16: width of the PLL reset pulse, in clk cycles (≥1).
- `LOCK_CYCLES`, 1024: consecutive synchronized-lock cycles required before lock is accepted (≥1).
- `HOLD_CYCLES`, 64: extra cycles `core_rst` is held after lock is accepted (≥1).
- `TIMEOUT_CYCLES`, 65536: maximum wait for lock before the PLL is reset again (≥2).
- `CW`, 17: counter width; must hold the largest of the four counts minus 1.

Ports:

- `clk`  in  1: 50 MHz reference clock; the only clock.
- `rst`  in  1: synchronous, active-high reset.
- `req_reset`  in  1: single-cycle request to re-run the full sequence (OSD/user).
- `pll_locked`  in  1: PLL lock, asynchronous to `clk`.
- `pll_rst`  out  1: PLL reset.
- `core_rst`  out  1: reset for the core clock domain; the consumer resynchronizes it.
- `ready`  out  1: sequence complete, PLL running.
- `retries`  out  4: lock-timeout count since `rst`, saturating at 15.

## Operation

- `pll_locked` passes through a 2-flop synchronizer; the result is `lock_s`, cleared to 0 by `rst`.
- FSM states, one-hot encoded: PLLRST, WAITLOCK, STABLE, HOLD, RUN.
- A shared counter `cnt[CW-1:0]` clears to 0 on every state entry and increments every cycle while the state holds.
- Outputs decode directly from the state flops, so they are glitch-free:
  - `pll_rst` = PLLRST.
  - `core_rst` = !RUN.
  - `ready` = RUN.
- Transition priority, highest first: `rst` > `req_reset` > lock events > counter expiry.
- Transitions:
  - Any state, `req_reset`=1 → PLLRST. `retries` is unchanged.
  - PLLRST, `cnt`==RST_CYCLES-1 → WAITLOCK.
  - WAITLOCK, `lock_s`=1 → STABLE.
  - WAITLOCK, `cnt`==TIMEOUT_CYCLES-1 with `lock_s`=0 → PLLRST and `retries`+1 (saturates at 15). If lock and timeout happen in the same cycle, lock wins.
  - STABLE, `lock_s`=0 → WAITLOCK. The timeout restarts from 0.
  - STABLE, `cnt`==LOCK_CYCLES-1 with `lock_s`=1 → HOLD.
  - HOLD, `lock_s`=0 → WAITLOCK.
  - HOLD, `cnt`==HOLD_CYCLES-1 → RUN.
  - RUN, `lock_s`=0 → PLLRST. `retries` is unchanged. `core_rst` reasserts the next cycle.
- On reset: state=PLLRST, `cnt`=0, `pll_rst`=1, `core_rst`=1, `ready`=0, `retries`=0, synchronizer flops=0.
- `rst` asserted mid-sequence forces the reset values on the next edge, whatever state the FSM is in.
- The counter never wraps; every state leaves at or before its terminal count.

## Timing

- Cycle 0 is the first cycle in which `rst` is sampled low.
- PLLRST occupies cycles 0..RST_CYCLES-1.
- If `lock_s` is already 1 on WAITLOCK entry, WAITLOCK lasts exactly 1 cycle.
- STABLE lasts LOCK_CYCLES cycles, and HOLD lasts HOLD_CYCLES cycles.
- `core_rst` falls and `ready` rises in cycle RST_CYCLES+1+LOCK_CYCLES+HOLD_CYCLES.
- A change in `pll_locked` reaches the FSM's decision 2 cycles later, through the synchronizer. The resulting output change appears 1 cycle after that decision.
- `req_reset` sampled high in cycle n puts `pll_rst`=1 and `core_rst`=1 in cycle n+1.

## Structure

- Package `pll_seq_pkg`: the state enum (one-hot `localparam` encodings) and default parameter values shared with the top level.
- One sub-module, `pll_lock_sync`: the 2-flop synchronizer with synchronous reset. Instantiate it once.
- Everything else (FSM, counter, retry counter) lives in `pll_rst_seq`.

## Test plan

All scenarios use RST_CYCLES=4, LOCK_CYCLES=8, HOLD_CYCLES=4, TIMEOUT_CYCLES=32.

- **Clean start:** `pll_locked` held at 1 through reset → `pll_rst`=1 in cycles 0..3; `core_rst` falls and `ready` rises in cycle 17; `retries`=0.
- **Lock timeout:** `pll_locked` held at 0 → `pll_rst` pulses of 4 cycles recur every 36 cycles; `retries` reaches 15 after 15 timeouts and stays at 15.
- **Lock glitch in STABLE:** `pll_locked` drops for 1 cycle while in STABLE → FSM returns to WAITLOCK with no `pll_rst` pulse; `ready` rises 2+8+4 cycles after lock returns, plus synchronizer delay.
- **Lock loss in RUN:** `pll_locked` falls at cycle 40 → `core_rst`=1 and `pll_rst`=1 at cycle 43, held for 4 cycles; `retries` unchanged.
- **User request:** `req_reset` pulsed at cycle 30 while in RUN → `pll_rst` asserted cycles 31..34; `ready` returns at cycle 31+17.
- **Reset mid-sequence:** `rst` asserted during STABLE for 1 cycle → all outputs return to reset values on the next cycle; the sequence restarts from cycle 0 after `rst` falls; `retries`=0.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset/lock sequencer: one-hot state
// encodings, bit positions used for output decode, and default timings.
package pll_seq_pkg;

    localparam int ST_PLLRST_BIT   = 0;
    localparam int ST_WAITLOCK_BIT = 1;
    localparam int ST_STABLE_BIT   = 2;
    localparam int ST_HOLD_BIT     = 3;
    localparam int ST_RUN_BIT      = 4;

    typedef enum logic [4:0] {
        ST_PLLRST   = 5'b00001,
        ST_WAITLOCK = 5'b00010,
        ST_STABLE   = 5'b00100,
        ST_HOLD     = 5'b01000,
        ST_RUN      = 5'b10000
    } state_t;

    localparam int RST_CYCLES_DEF     = 16;
    localparam int LOCK_CYCLES_DEF    = 1024;
    localparam int HOLD_CYCLES_DEF    = 64;
    localparam int TIMEOUT_CYCLES_DEF = 65536;
    localparam int CW_DEF             = 17;

    localparam logic [3:0] RETRY_MAX = 4'd15;

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL lock into the
// reference clock domain; both stages clear on synchronous reset.
module pll_lock_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/pll_rst_seq.sv
// PLL reset and lock sequencer: pulses the PLL reset, qualifies a stable
// lock, holds the core in reset a little longer, and restarts on trouble.
module pll_rst_seq
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES     = RST_CYCLES_DEF,
    parameter int LOCK_CYCLES    = LOCK_CYCLES_DEF,
    parameter int HOLD_CYCLES    = HOLD_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int CW             = CW_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_reset,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       core_rst,
    output logic       ready,
    output logic [3:0] retries,
    output state_t     dbg_state
);

    localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_LAST    = CW'(LOCK_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic          lock_s;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    retries_q, retries_d;
    logic          restart;

    pll_lock_sync u_lock_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (pll_locked),
        .sync_out (lock_s)
    );

    always_comb begin
        state_d   = state_q;
        retries_d = retries_q;
        restart   = 1'b0;
        if (req_reset) begin
            state_d = ST_PLLRST;
            restart = 1'b1;
        end else begin
            case (state_q)
                ST_PLLRST: begin
                    if (cnt_q == RST_LAST) state_d = ST_WAITLOCK;
                end
                ST_WAITLOCK: begin
                    // A lock seen on the terminal cycle still counts as a lock.
                    if (lock_s) begin
                        state_d = ST_STABLE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_d = ST_PLLRST;
                        if (retries_q != RETRY_MAX) retries_d = retries_q + 4'd1;
                    end
                end
                ST_STABLE: begin
                    if (!lock_s)                state_d = ST_WAITLOCK;
                    else if (cnt_q == LOCK_LAST) state_d = ST_HOLD;
                end
                ST_HOLD: begin
                    if (!lock_s)                state_d = ST_WAITLOCK;
                    else if (cnt_q == HOLD_LAST) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (!lock_s) state_d = ST_PLLRST;
                end
                default: state_d = ST_PLLRST;
            endcase
        end

        // RUN has no terminal count, so its counter parks at zero rather than wrapping.
        if (restart || (state_d != state_q) || (state_q == ST_RUN)) cnt_d = '0;
        else                                                         cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_PLLRST;
            cnt_q     <= '0;
            retries_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retries_q <= retries_d;
        end
    end

    assign pll_rst   = state_q[ST_PLLRST_BIT];
    assign core_rst  = ~state_q[ST_RUN_BIT];
    assign ready     = state_q[ST_RUN_BIT];
    assign retries   = retries_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Bench for pll_rst_seq: directed scenarios plus random lock/request traffic,
// checked every cycle against a phase/elapsed-time reference model.
module tb_pll_rst_seq;
    import pll_seq_pkg::*;

    localparam int T_RST     = 4;
    localparam int T_LOCK    = 8;
    localparam int T_HOLD    = 4;
    localparam int T_TIMEOUT = 32;

    localparam int P_RST    = 0;
    localparam int P_WAIT   = 1;
    localparam int P_STABLE = 2;
    localparam int P_HOLD   = 3;
    localparam int P_RUN    = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_reset = 1'b0;
    logic       pll_locked = 1'b0;
    logic       pll_rst, core_rst, ready;
    logic [3:0] retries;
    state_t     dbg_state;

    logic [6:0] exp_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;

    // reference model state
    int   m_phase   = P_RST;
    int   m_elapsed = 0;
    int   m_retries = 0;
    logic sync_pipe[$];
    int   dur[5] = '{T_RST, T_TIMEOUT, T_LOCK, T_HOLD, 0};

    pll_rst_seq #(
        .RST_CYCLES     (T_RST),
        .LOCK_CYCLES    (T_LOCK),
        .HOLD_CYCLES    (T_HOLD),
        .TIMEOUT_CYCLES (T_TIMEOUT),
        .CW             (6)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_reset  (req_reset),
        .pll_locked (pll_locked),
        .pll_rst    (pll_rst),
        .core_rst   (core_rst),
        .ready      (ready),
        .retries    (retries),
        .dbg_state  (dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
        $fatal(1, "watchdog");
    end

    function automatic void enter(input int p);
        m_phase   = p;
        m_elapsed = 0;
    endfunction

    // Advance the model over one clock edge given the inputs of the ended cycle.
    function automatic void model_edge(input logic r, input logic req, input logic lk);
        logic ls;
        bit   last;
        if (r) begin
            enter(P_RST);
            m_retries = 0;
            sync_pipe = '{1'b0, 1'b0};
            return;
        end
        ls   = sync_pipe[0];
        last = (m_elapsed + 1 == dur[m_phase]);
        if (req)                                  enter(P_RST);
        else if (m_phase == P_RST && last)        enter(P_WAIT);
        else if (m_phase == P_WAIT && ls)         enter(P_STABLE);
        else if (m_phase == P_WAIT && last) begin
            enter(P_RST);
            m_retries = (m_retries < 15) ? m_retries + 1 : 15;
        end
        else if ((m_phase == P_STABLE || m_phase == P_HOLD) && !ls) enter(P_WAIT);
        else if (m_phase == P_STABLE && last)     enter(P_HOLD);
        else if (m_phase == P_HOLD && last)       enter(P_RUN);
        else if (m_phase == P_RUN && !ls)         enter(P_RST);
        else                                      m_elapsed++;
        void'(sync_pipe.pop_front());
        sync_pipe.push_back(lk);
    endfunction

    function automatic logic [6:0] model_out();
        logic [3:0] rt;
        rt = 4'(m_retries);
        return {m_phase == P_RST, m_phase != P_RUN, m_phase == P_RUN, rt};
    endfunction

    // driver: inputs change on the falling edge, expectations queued after the rising edge
    task automatic step(input logic r, input logic req, input logic lk);
        @(negedge clk);
        rst        = r;
        req_reset  = req;
        pll_locked = lk;
        @(posedge clk);
        model_edge(r, req, lk);
        exp_q.push_back(model_out());
    endtask

    task automatic run(input int n, input logic lk);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, lk);
    endtask

    task automatic do_reset(input logic lk);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, lk);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [6:0] exp_v, got_v;
            exp_v = exp_q.pop_front();
            got_v = {pll_rst, core_rst, ready, retries};
            n_tests++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL outputs cyc=%0d {pll_rst,core_rst,ready,retries} got=%b exp=%b",
                         cyc, got_v, exp_v);
            end
            cyc++;
        end
    end

    initial begin
        sync_pipe = '{1'b0, 1'b0};

        // clean start: lock held high throughout
        do_reset(1'b1);
        run(30, 1'b1);

        // lock never arrives: repeated timeouts, retries saturate
        do_reset(1'b0);
        run(16 * (T_RST + T_TIMEOUT) + 40, 1'b0);

        // one-cycle lock glitch while in STABLE
        do_reset(1'b1);
        run(7, 1'b1);
        run(1, 1'b0);
        run(30, 1'b1);

        // lock loss in RUN at cycle 40
        do_reset(1'b1);
        run(40, 1'b1);
        run(10, 1'b0);
        run(30, 1'b1);

        // user request at cycle 30
        do_reset(1'b1);
        run(30, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        run(25, 1'b1);

        // reset pulse during STABLE, after a timeout bumped retries
        do_reset(1'b0);
        run(T_RST + T_TIMEOUT + 2, 1'b0);
        run(8, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        run(25, 1'b1);

        // request in the very first PLLRST cycles and on a WAITLOCK timeout edge
        do_reset(1'b0);
        run(2, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        run(T_RST + T_TIMEOUT - 1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        run(10, 1'b0);

        // random traffic
        do_reset(1'b1);
        for (int seg = 0; seg < 60; seg++) begin
            int   len;
            logic lk;
            len = $urandom_range(1, 40);
            lk  = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < len; i++)
                step($urandom_range(0, 299) == 0, $urandom_range(0, 99) == 0, lk);
        end

        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: expectations left got=%0d need=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
